// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl
//   Game-state controller for the OLED reaction-time game. It runs a random
//   pre-signal delay, measures the reaction time in milliseconds, catches
//   presses made before the signal and drives the screen-select code that the
//   downstream screen mux uses.
//
// Ports
//   clk         system clock (single domain)
//   reset       synchronous, active-high reset
//   btn_pulse   one-cycle debounced press pulse
//   screen_sel  screen code: 0 IDLE, 10 WAIT, 11 GO, 12 TOO_EARLY,
//               13 RESULT, 14 TIMEOUT
//   react_ms    last measured reaction time, ms
//   best_ms     best reaction time since reset (9999 = none)
//   early_cnt   too-early press count, saturating at 255
//   go_led      high only in GO
module reaction_game_ctrl #(
  parameter int unsigned TICKS_PER_MS = 6250,
  parameter int unsigned HOLD_MS      = 2000,
  parameter int unsigned TIMEOUT_MS   = 9999,
  parameter int unsigned BASE_MS      = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_pulse,
  output logic [3:0]  screen_sel,
  output logic [13:0] react_ms,
  output logic [13:0] best_ms,
  output logic [7:0]  early_cnt,
  output logic        go_led
);

  localparam int unsigned    PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]    TIMEOUT_V  = 14'(TIMEOUT_MS);
  localparam logic [13:0]    HOLD_V     = 14'(HOLD_MS);
  localparam logic [13:0]    BASE_V     = 14'(BASE_MS);
  localparam logic [15:0]    LFSR_SEED  = 16'hACE1;

  // State encodings double as the screen codes so screen_sel is the state register.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WAIT    = 4'd10,
    S_GO      = 4'd11,
    S_EARLY   = 4'd12,
    S_RESULT  = 4'd13,
    S_TIMEOUT = 4'd14
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [PW-1:0]  presc;
  logic           ms_tick;
  logic [13:0]    ms_cnt;      // WAIT: remaining delay, GO: reaction, EARLY: hold
  logic [13:0]    ms_cnt_nx;
  logic [13:0]    go_inc;
  logic [13:0]    react_val;
  logic [15:0]    lfsr;
  logic           lfsr_fb;

  assign ms_tick    = (presc == PRESC_LAST);
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign screen_sel = state;

  // A press on a tick cycle counts that tick; this is what makes a press on
  // the timeout tick report TIMEOUT_MS.
  assign go_inc    = ms_tick ? (ms_cnt + 14'd1) : ms_cnt;
  assign react_val = (go_inc >= TIMEOUT_V) ? TIMEOUT_V : go_inc;

  always_comb begin
    state_nx  = state;
    ms_cnt_nx = ms_cnt;
    case (state)
      S_IDLE: begin
        if (btn_pulse) begin
          state_nx  = S_WAIT;
          ms_cnt_nx = BASE_V + 14'(lfsr[10:0]);
        end
      end
      S_WAIT: begin
        // Press has priority over an expiring delay.
        if (btn_pulse) begin
          state_nx  = S_EARLY;
          ms_cnt_nx = '0;
        end else if (ms_tick) begin
          if (ms_cnt <= 14'd1) begin
            state_nx  = S_GO;
            ms_cnt_nx = '0;
          end else begin
            ms_cnt_nx = ms_cnt - 14'd1;
          end
        end
      end
      S_GO: begin
        if (btn_pulse) begin
          state_nx = S_RESULT;
        end else if (ms_tick && (go_inc >= TIMEOUT_V)) begin
          state_nx = S_TIMEOUT;
        end else begin
          ms_cnt_nx = go_inc;
        end
      end
      S_EARLY: begin
        if (ms_tick) begin
          if ((ms_cnt + 14'd1) >= HOLD_V) begin
            state_nx = S_IDLE;
          end else begin
            ms_cnt_nx = ms_cnt + 14'd1;
          end
        end
      end
      S_RESULT, S_TIMEOUT: begin
        if (btn_pulse) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      presc     <= '0;
      ms_cnt    <= '0;
      lfsr      <= LFSR_SEED;
      react_ms  <= '0;
      best_ms   <= 14'd9999;
      early_cnt <= '0;
      go_led    <= 1'b0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr_fb};
      state  <= state_nx;
      ms_cnt <= ms_cnt_nx;
      go_led <= (state_nx == S_GO);

      // Prescaler restarts on every transition so each state's first tick
      // lands exactly TICKS_PER_MS cycles after entry.
      if ((state_nx != state) || ms_tick) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      if ((state == S_WAIT) && btn_pulse && (early_cnt != 8'hFF)) begin
        early_cnt <= early_cnt + 8'd1;
      end

      if ((state == S_GO) && (state_nx == S_RESULT)) begin
        react_ms <= react_val;
        if (react_val < best_ms) begin
          best_ms <= react_val;
        end
      end

      if ((state == S_GO) && (state_nx == S_TIMEOUT)) begin
        react_ms <= TIMEOUT_V;
      end
    end
  end

endmodule
